// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequential 32x32 shift-add multiplier built on one 32-bit add
//
// add     : 32-bit adder, sum plus carry_out
//   a, b        in  32  operands
//   sum         out 32  a + b (low 32 bits)
//   carry_out   out 1   bit 32 of a + b
//
// mul_seq : 32 shift-add steps per operation, valid/ready on both sides
//   clk         in  1   rising-edge clock
//   rst_n       in  1   synchronous active-low reset
//   in_valid    in  1   operands a/b are valid
//   in_ready    out 1   block can accept operands (IDLE only)
//   a           in  32  multiplicand
//   b           in  32  multiplier
//   signed_mode in  1   two's-complement operands (only with MUL_SIGNED_EN)
//   out_valid   out 1   product valid (DONE)
//   out_ready   in  1   consumer takes product
//   product     out 64  result, zero outside DONE
//   busy        out 1   high in CALC or DONE
//
// Optional feature macro: MUL_SIGNED_EN adds signed_mode and sign correction.

module add (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum,
   output logic        carry_out
);
   assign {carry_out, sum} = {1'b0, a} + {1'b0, b};
endmodule

module mul_seq #(
   parameter int CNT_W = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
`ifdef MUL_SIGNED_EN
   input  logic        signed_mode,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] product,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(31);

   state_t             state, state_nx;
   logic [31:0]        mcand, hi, lo;
   logic [CNT_W-1:0]   cnt;
   logic [31:0]        add_b, add_sum;
   logic               add_co;
   logic               accept;
   logic [31:0]        a_lat, b_lat;
   logic [63:0]        raw;

   // Single adder: partial high word plus multiplicand gated by the current multiplier bit.
   assign add_b = lo[0] ? mcand : 32'd0;

   add u_add (
      .a         (hi),
      .b         (add_b),
      .sum       (add_sum),
      .carry_out (add_co)
   );

   assign accept = in_valid && in_ready;
   assign raw    = {hi, lo};

`ifdef MUL_SIGNED_EN
   logic sign_flag;
   // Magnitudes are latched; -2^31 maps onto itself, which is its correct unsigned magnitude.
   assign a_lat = (signed_mode && a[31]) ? (~a + 32'd1) : a;
   assign b_lat = (signed_mode && b[31]) ? (~b + 32'd1) : b;
`else
   assign a_lat = a;
   assign b_lat = b;
`endif

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      product   = 64'd0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (cnt == LAST_STEP) state_nx = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
`ifdef MUL_SIGNED_EN
            product   = sign_flag ? (~raw + 64'd1) : raw;
`else
            product   = raw;
`endif
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         mcand <= 32'd0;
         hi    <= 32'd0;
         lo    <= 32'd0;
         cnt   <= '0;
`ifdef MUL_SIGNED_EN
         sign_flag <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (accept) begin
                  mcand <= a_lat;
                  hi    <= 32'd0;
                  lo    <= b_lat;
                  cnt   <= '0;
`ifdef MUL_SIGNED_EN
                  sign_flag <= signed_mode & (a[31] ^ b[31]);
`endif
               end
            end
            CALC: begin
               // {hi,lo} <= {carry_out, sum, lo} >> 1; carry_out becomes the new hi MSB.
               hi  <= {add_co, add_sum[31:1]};
               lo  <= {add_sum[0], lo[31:1]};
               cnt <= cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - self-checking bench for mul_seq

module tb_mul_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        signed_mode;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] product;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mul_seq #(.CNT_W(6)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
`ifdef MUL_SIGNED_EN
      .signed_mode (signed_mode),
`endif
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .product     (product),
      .busy        (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic sm);
      longint sp;
      if (sm) begin
         sp = longint'($signed(ma)) * longint'($signed(mb));
         return 64'(sp);
      end
      return {32'd0, ma} * {32'd0, mb};
   endfunction

   // One full operation: accept, wait with a bounded budget, check latency/product,
   // optionally stall the consumer, then transfer and confirm return to IDLE.
   task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic sm,
                        input int hold, input bit toggle);
      logic [63:0] exp;
      int n;
      exp = model(ta, tb_, sm);
      @(negedge clk);
      chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
      a = ta; b = tb_; signed_mode = sm; in_valid = 1'b1;
      out_ready = (hold == 0);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         if (n == 5) begin
            chk("in_ready_calc", {63'd0, in_ready}, 64'd0);
            chk("busy_calc", {63'd0, busy}, 64'd1);
         end
         if (toggle) begin
            in_valid = 1'($urandom);
            a = $urandom; b = $urandom; signed_mode = 1'($urandom);
         end
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      chk("latency", 64'(n), 64'd32);
      chk("product", product, exp);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         a = $urandom; b = $urandom;
         @(negedge clk);
         chk("hold_valid", {63'd0, out_valid}, 64'd1);
         chk("hold_product", product, exp);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("valid_drop", {63'd0, out_valid}, 64'd0);
      chk("in_ready_after", {63'd0, in_ready}, 64'd1);
      chk("busy_after", {63'd0, busy}, 64'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      int seen;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_product", product, 64'd0);
      rst_n = 1'b1;

      do_op(32'd3, 32'd5, 1'b0, 0, 1'b0);
      chk("p_3x5", model(32'd3, 32'd5, 1'b0), 64'h0000_0000_0000_000F);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
      do_op(32'h1234_5678, 32'd0, 1'b0, 0, 1'b1);
      do_op(32'd0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
      do_op(32'h0001_0000, 32'h0001_0000, 1'b0, 10, 1'b0);

      // Reset at step 15 aborts the operation with no output.
      @(negedge clk);
      a = 32'd7; b = 32'd9; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (15) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_product", product, 64'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_valid", 64'(seen), 64'd0);
      out_ready = 1'b0;
      do_op(32'd2, 32'd4, 1'b0, 0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         do_op($urandom, $urandom, 1'b0, int'($urandom_range(0, 3)), 1'($urandom));
      end

`ifdef MUL_SIGNED_EN
      do_op(32'hFFFF_FFFD, 32'd7, 1'b1, 0, 1'b0);
      do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1'b0);
      do_op(32'hFFFF_FFFD, 32'd7, 1'b0, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         do_op($urandom, $urandom, 1'b1, 0, 1'b0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
